despachador_trabajo: RTL and testbench
======================================

// Module: despachador_trabajo
// PURPOSE
//  Upstream feeder for the vector-unit consumer stage. Buffers 6-bit job codes from
//  the issue side in a small FIFO and hands them to the consumer one at a time.
//  Each job is driven on trabajo_o for exactly one cycle. The next job is issued only
//  after the consumer's busy has risen (acknowledge) and then fallen (done).
//  A job code of 0 means "no work" on the consumer side, so it is never forwarded.
// PARAMETERS
//  JOB_W        6  width of a job code
//  DEPTH        4  FIFO entries; power of two, >=2
//  ACK_TIMEOUT  2  max cycles in WAIT_ACK before abandoning the job
// PORTS
//  clk_i        in   1              clock, rising edge
//  rst_ni       in   1              asynchronous reset, active low
//  job_i        in   JOB_W          job code from issue side
//  job_valid_i  in   1              job_i valid
//  job_ready_o  out  1              FIFO can accept (count_o < DEPTH)
//  trabajo_o    out  JOB_W          registered job to consumer; 0 = no work
//  busy_i       in   1              consumer busy
//  count_o      out  $clog2(DEPTH)+1  FIFO occupancy
//  idle_o       out  1              FIFO empty and FSM in IDLE
//  drop_o       out  1              1-cycle pulse: zero job accepted and discarded
//  err_o        out  1              sticky: ack timeout occurred
// BEHAVIOUR
//  Reset (async, rst_ni=0): FIFO pointers/count=0, FSM=IDLE, trabajo_o=0, drop_o=0,
//   err_o=0, job_ready_o=1, idle_o=1. Takes effect immediately, including mid-issue.
//   In-flight and queued jobs are lost.
//  Accept: job_valid_i & job_ready_o at a rising edge.
//   - job_i!=0: pushed at the tail.
//   - job_i==0: consumed, not stored; drop_o=1 for the following cycle.
//   - job_ready_o = (count_o<DEPTH), combinational from count only.
//   - No bypass: when full, a pop in the same cycle does not raise ready.
//  Pointers: wrap modulo DEPTH. Push and pop in the same cycle leave count unchanged.
//  FSM (registered; trabajo_o is driven only from a register):
//   IDLE      : if count_o>0 & !busy_i -> pop head into trabajo_o, go ISSUE.
//               A push in this same cycle to an empty FIFO does not qualify.
//   ISSUE     : trabajo_o holds the job for this single cycle.
//               Next edge: trabajo_o<=0, ack counter<=0, go WAIT_ACK.
//   WAIT_ACK  : if busy_i -> WAIT_DONE.
//               Else counter++; when counter==ACK_TIMEOUT-1 and !busy_i:
//               err_o<=1 and go IDLE (job abandoned).
//   WAIT_DONE : if !busy_i -> IDLE. No timeout.
//  Latency: job accepted at edge E into an empty FIFO with busy_i=0
//   -> trabajo_o!=0 during cycle E+1..E+2 (one cycle).
//   -> consumer samples the job at E+2; busy_i is expected high after E+2.
//  Back-to-back: the next issue needs busy_i to fall, then the IDLE check. A busy_i that
//   is high at IDLE blocks issue. Exactly one outstanding job at a time.
//  busy_i already high in ISSUE or WAIT_ACK counts as acknowledge.
//  idle_o = (state==IDLE) & (count_o==0).
// TESTING
//  1 Reset: assert rst_ni=0 mid-ISSUE -> trabajo_o=0 at once, count_o=0, idle_o=1,
//    err_o=0.
//  2 Single job: push 6'h15 into empty FIFO, consumer model (busy 1 cycle after job,
//    held 4 cycles) -> trabajo_o=6'h15 for exactly 1 cycle, 2 cycles after accept;
//    idle_o=1 after busy_i falls.
//  3 Fill: push 6'h01..6'h05 with busy_i forced high -> 4 accepted, job_ready_o=0
//    with 6'h05 stalled. Release busy_i -> issue order 01,02,03,04,05, each separated
//    by a full busy cycle.
//  4 Zero job: push 6'h00 then 6'h07 -> drop_o pulses once, count_o peaks at 1,
//    only 6'h07 appears on trabajo_o.
//  5 Timeout: push 6'h2A with busy_i tied 0 -> trabajo_o pulses once; 2 cycles later
//    err_o=1 (sticky); next queued job still issues.
//  6 Wrap: stream 3*DEPTH random nonzero jobs with random valid and consumer timing ->
//    output sequence equals input sequence, never two trabajo_o pulses within one
//    busy window.

Source files
------------

// File: rtl/despachador_trabajo.sv
// -----------------------------------------------------------------------------
// despachador_trabajo
// Upstream feeder for the vector-unit consumer stage. Job codes from the issue
// side are buffered in a small FIFO and handed to the consumer one at a time.
// Each job is shown on trabajo_o for exactly one cycle. The next job is issued
// only after the consumer's busy has risen (acknowledge) and fallen (done).
// A zero job code means "no work" downstream, so it is accepted and discarded.
//
// Ports
//   clk_i        in   clock, rising edge
//   rst_ni       in   asynchronous reset, active low
//   job_i        in   job code from issue side
//   job_valid_i  in   job_i valid
//   job_ready_o  out  FIFO can accept (count_o < DEPTH), from count only
//   trabajo_o    out  registered job to consumer; 0 = no work
//   busy_i       in   consumer busy
//   count_o      out  FIFO occupancy
//   idle_o       out  FIFO empty and dispatcher idle
//   drop_o       out  one-cycle pulse: a zero job was accepted and discarded
//   err_o        out  sticky: consumer never acknowledged an issued job
// -----------------------------------------------------------------------------
module despachador_trabajo #(
  parameter int JOB_W       = 6,
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [JOB_W-1:0]         job_i,
  input  logic                     job_valid_i,
  output logic                     job_ready_o,
  output logic [JOB_W-1:0]         trabajo_o,
  input  logic                     busy_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     idle_o,
  output logic                     drop_o,
  output logic                     err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [JOB_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [JOB_W-1:0]   trabajo_q, trabajo_d;
  logic [ACK_W-1:0]   ack_cnt_q, ack_cnt_d;
  logic               err_q, err_d;
  logic               drop_q, drop_d;
  logic               accept_s;
  logic               push_s;
  logic               pop_s;

  // Ready depends on registered count only, so a same-cycle pop never bypasses a full FIFO.
  assign job_ready_o = (count_q < CNT_W'(DEPTH));
  assign accept_s    = job_valid_i & job_ready_o;
  assign push_s      = accept_s & (job_i != '0);
  assign drop_d      = accept_s & (job_i == '0);

  assign trabajo_o = trabajo_q;
  assign count_o   = count_q;
  assign err_o     = err_q;
  assign drop_o    = drop_q;
  assign idle_o    = (state_q == ST_IDLE) & (count_q == '0);

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Dispatcher FSM next-state and registered outputs.
  always_comb begin
    state_d   = state_q;
    trabajo_d = '0;
    ack_cnt_d = ack_cnt_q;
    err_d     = err_q;
    pop_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // count_q is registered: a push this cycle into an empty FIFO cannot issue yet.
        if ((count_q != '0) && !busy_i) begin
          pop_s     = 1'b1;
          trabajo_d = mem_q[rd_ptr_q];
          state_d   = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        ack_cnt_d = '0;
        // A consumer already busy while the job is shown has acknowledged it.
        if (busy_i) begin
          state_d = ST_WAIT_DONE;
        end else begin
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (busy_i) begin
          state_d = ST_WAIT_DONE;
        end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!busy_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      trabajo_q <= '0;
      ack_cnt_q <= '0;
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      trabajo_q <= trabajo_d;
      ack_cnt_q <= ack_cnt_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
    end
  end

  // FIFO storage; only nonzero jobs are written.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= job_i;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

endmodule

// File: tb/tb_despachador_trabajo.sv
// -----------------------------------------------------------------------------
// tb_despachador_trabajo
// Scoreboard bench: every nonzero job accepted by the DUT is queued as expected
// output; a monitor pops and compares whenever trabajo_o shows a job. A simple
// consumer model raises busy after each job. Directed checks cover reset,
// latency, fill/stall, zero-job drop, ack timeout and a pointer-wrap stream.
// -----------------------------------------------------------------------------
module tb_despachador_trabajo;

  logic       clk_s;
  logic       rst_n_s;
  logic [5:0] job_s;
  logic       job_valid_s;
  logic       job_ready_s;
  logic [5:0] trabajo_s;
  logic       busy_s;
  logic [2:0] count_s;
  logic       idle_s;
  logic       drop_s;
  logic       err_s;

  logic       force_busy_s;
  logic       cons_busy_s;
  logic       cons_en_s;
  logic       cons_rand_s;
  int         cons_dly_s;
  int         cons_hold_s;
  logic       chk_busy_s;

  logic [5:0] exp_q[$];
  int         checks;
  int         errors;
  logic       pulse_pend;
  logic       seen_pulse;
  logic       ack_seen;

  assign busy_s = force_busy_s | cons_busy_s;

  despachador_trabajo #(
    .JOB_W(6), .DEPTH(4), .ACK_TIMEOUT(2)
  ) dut (
    .clk_i       (clk_s),
    .rst_ni      (rst_n_s),
    .job_i       (job_s),
    .job_valid_i (job_valid_s),
    .job_ready_o (job_ready_s),
    .trabajo_o   (trabajo_s),
    .busy_i      (busy_s),
    .count_o     (count_s),
    .idle_o      (idle_s),
    .drop_o      (drop_s),
    .err_o       (err_s)
  );

  initial clk_s = 1'b0;
  always #5 clk_s = ~clk_s;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [5:0] j);
    int n;
    n = 0;
    job_s = j;
    job_valid_s = 1'b1;
    while (!job_ready_s && n < 200) begin
      @(negedge clk_s);
      n++;
    end
    chk("push_accept", job_ready_s, 1);
    if (j != 6'h00) exp_q.push_back(j);
    @(negedge clk_s);
    job_valid_s = 1'b0;
    job_s = 6'h00;
  endtask

  task automatic wait_quiet();
    int n;
    int stable;
    n = 0;
    stable = 0;
    while (stable < 3 && n < 1000) begin
      @(negedge clk_s);
      n++;
      if (idle_s && !busy_s && exp_q.size() == 0) stable++;
      else stable = 0;
    end
    chk("quiet", (stable >= 3) ? 1 : 0, 1);
  endtask

  // Consumer model: busy rises cons_dly negedges after a job is seen, held cons_hold cycles.
  always begin
    @(negedge clk_s);
    if (cons_en_s && trabajo_s != 6'h00) begin
      if (cons_rand_s) begin
        cons_dly_s  = $urandom_range(1, 2);
        cons_hold_s = $urandom_range(1, 5);
      end
      repeat (cons_dly_s) @(negedge clk_s);
      cons_busy_s = 1'b1;
      repeat (cons_hold_s) @(negedge clk_s);
      cons_busy_s = 1'b0;
    end
  end

  // Monitor: compares each issued job against the scoreboard and checks pulse shape.
  always @(negedge clk_s) begin
    logic [5:0] exp_j;
    if (pulse_pend) begin
      chk("pulse_width", trabajo_s, 0);
      pulse_pend = 1'b0;
    end else if (trabajo_s != 6'h00) begin
      pulse_pend = 1'b1;
      if (exp_q.size() == 0) begin
        chk("unexpected_job", trabajo_s, 0);
      end else begin
        exp_j = exp_q.pop_front();
        chk("job_order", trabajo_s, exp_j);
      end
      if (chk_busy_s && seen_pulse) chk("busy_window", ack_seen, 1);
      seen_pulse = 1'b1;
      ack_seen   = 1'b0;
    end
    if (busy_s) ack_seen = 1'b1;
  end

  initial begin
    int n;
    checks = 0;
    errors = 0;
    pulse_pend = 1'b0;
    seen_pulse = 1'b0;
    ack_seen = 1'b0;
    rst_n_s = 1'b0;
    job_s = 6'h00;
    job_valid_s = 1'b0;
    force_busy_s = 1'b0;
    cons_busy_s = 1'b0;
    cons_en_s = 1'b1;
    cons_rand_s = 1'b0;
    cons_dly_s = 1;
    cons_hold_s = 4;
    chk_busy_s = 1'b1;

    // Power-on reset values
    repeat (2) @(negedge clk_s);
    chk("rst_trabajo", trabajo_s, 0);
    chk("rst_count", count_s, 0);
    chk("rst_idle", idle_s, 1);
    chk("rst_ready", job_ready_s, 1);
    chk("rst_err", err_s, 0);
    chk("rst_drop", drop_s, 0);
    rst_n_s = 1'b1;
    @(negedge clk_s);

    // Single job: visible exactly one cycle, two edges after accept
    push(6'h15);
    chk("single_lat0", trabajo_s, 0);
    chk("single_count", count_s, 1);
    @(negedge clk_s);
    chk("single_lat1", trabajo_s, 6'h15);
    chk("single_count_pop", count_s, 0);
    @(negedge clk_s);
    chk("single_lat2", trabajo_s, 0);
    wait_quiet();
    chk("single_idle", idle_s, 1);

    // Fill with busy forced high; fifth job stalls until the first issue
    force_busy_s = 1'b1;
    for (int k = 1; k <= 4; k++) push(6'(k));
    chk("fill_count", count_s, 4);
    job_s = 6'h05;
    job_valid_s = 1'b1;
    chk("fill_ready", job_ready_s, 0);
    chk("fill_idle", idle_s, 0);
    force_busy_s = 1'b0;
    n = 0;
    while (!job_ready_s && n < 100) begin
      @(negedge clk_s);
      n++;
    end
    chk("fill_release", job_ready_s, 1);
    exp_q.push_back(6'h05);
    @(negedge clk_s);
    job_valid_s = 1'b0;
    job_s = 6'h00;
    wait_quiet();

    // Zero job is dropped, only 07 reaches the consumer
    push(6'h00);
    chk("zero_drop", drop_s, 1);
    chk("zero_count", count_s, 0);
    push(6'h07);
    chk("zero_drop_once", drop_s, 0);
    chk("zero_count_peak", count_s, 1);
    @(negedge clk_s);
    chk("zero_count_after", count_s, 0);
    wait_quiet();

    // Ack timeout: 2A abandoned with err_o, queued 2B still issues
    cons_en_s = 1'b0;
    chk_busy_s = 1'b0;
    push(6'h2A);
    push(6'h2B);
    repeat (2) @(negedge clk_s);
    chk("tmo_err_pre", err_s, 0);
    @(negedge clk_s);
    chk("tmo_err_set", err_s, 1);
    cons_en_s = 1'b1;
    wait_quiet();
    chk("tmo_err_sticky", err_s, 1);
    chk_busy_s = 1'b1;

    // Async reset in the middle of an issue cycle clears everything at once
    push(6'h3C);
    push(6'h3D);
    chk("mid_issue_job", trabajo_s, 6'h3C);
    #2;
    rst_n_s = 1'b0;
    #1;
    chk("arst_trabajo", trabajo_s, 0);
    chk("arst_count", count_s, 0);
    chk("arst_idle", idle_s, 1);
    chk("arst_err", err_s, 0);
    chk("arst_ready", job_ready_s, 1);
    exp_q.delete();
    repeat (2) @(negedge clk_s);
    rst_n_s = 1'b1;
    wait_quiet();

    // Wrap stream: 3*DEPTH random jobs, random gaps and consumer timing
    cons_rand_s = 1'b1;
    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk_s);
      push(6'($urandom_range(1, 63)));
    end
    wait_quiet();
    chk("stream_drained", exp_q.size(), 0);
    chk("stream_err_clear", err_s, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
